// File: rtl/mul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mul_arbiter
//  Brief    : Two-requester round-robin front end for a shared 128-bit
//             multiplier, with per-operation watchdog.
//  Revision : 1.0
// ============================================================================
module mul_arbiter #(
    parameter int WD_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req0_multiplier,
    input  logic [63:0] req0_multiplicand,
    input  logic [63:0] req1_multiplier,
    input  logic [63:0] req1_multiplicand,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_done,
    output logic        err,
    output logic [63:0] out_result_h,
    output logic [63:0] out_result_l,
    output logic        owner,
    output logic        busy,
    output logic        mul_op_start,
    output logic        mul_op_clear,
    output logic [63:0] multiplier,
    output logic [63:0] multiplicand,
    input  logic        mul_op_done,
    input  logic [63:0] result_h,
    input  logic [63:0] result_l
);

    localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(WD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_grant;
    logic [WD_W-1:0] r_wd_cnt;
    logic            w_winner;

    // With both requesting, the one not served last time goes first.
    assign w_winner = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_wd_cnt     <= '0;
            req_ack      <= 2'b00;
            req_done     <= 2'b00;
            err          <= 1'b0;
            out_result_h <= '0;
            out_result_l <= '0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            mul_op_start <= 1'b0;
            mul_op_clear <= 1'b1;
            multiplier   <= '0;
            multiplicand <= '0;
        end else begin
            req_ack  <= 2'b00;
            req_done <= 2'b00;
            err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner        <= w_winner;
                        req_ack      <= {w_winner, ~w_winner};
                        multiplier   <= w_winner ? req1_multiplier   : req0_multiplier;
                        multiplicand <= w_winner ? req1_multiplicand : req0_multiplicand;
                        busy         <= 1'b1;
                        mul_op_clear <= 1'b1;
                        r_state      <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    mul_op_clear <= 1'b0;
                    mul_op_start <= 1'b1;
                    r_wd_cnt     <= '0;
                    r_state      <= ST_RUN;
                end
                ST_RUN: begin
                    // A completion seen on the limit cycle still counts as success.
                    if (mul_op_done) begin
                        out_result_h <= result_h;
                        out_result_l <= result_l;
                        req_done     <= {owner, ~owner};
                        mul_op_start <= 1'b0;
                        mul_op_clear <= 1'b1;
                        r_state      <= ST_RSP;
                    end else if (r_wd_cnt == c_wd_last) begin
                        out_result_h <= '0;
                        out_result_l <= '0;
                        req_done     <= {owner, ~owner};
                        err          <= 1'b1;
                        mul_op_start <= 1'b0;
                        mul_op_clear <= 1'b1;
                        r_state      <= ST_RSP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ST_RSP: begin
                    r_last_grant <= owner;
                    busy         <= 1'b0;
                    mul_op_clear <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mul_arbiter
//  Brief    : Scoreboard bench for mul_arbiter with a latency-programmable
//             multiplier model.
//  Revision : 1.0
// ============================================================================
module tb_mul_arbiter;

    localparam int WD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [63:0] req0_multiplier = '0, req0_multiplicand = '0;
    logic [63:0] req1_multiplier = '0, req1_multiplicand = '0;
    logic [1:0]  req_ack, req_done;
    logic        err, owner, busy, mul_op_start, mul_op_clear;
    logic [63:0] out_result_h, out_result_l, multiplier, multiplicand;
    logic        mul_op_done = 1'b0;
    logic [63:0] result_h = '0, result_l = '0;

    always #5 clk = ~clk;

    mul_arbiter #(.WD_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_multiplier(req0_multiplier), .req0_multiplicand(req0_multiplicand),
        .req1_multiplier(req1_multiplier), .req1_multiplicand(req1_multiplicand),
        .req_ack(req_ack), .req_done(req_done), .err(err),
        .out_result_h(out_result_h), .out_result_l(out_result_l),
        .owner(owner), .busy(busy),
        .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .mul_op_done(mul_op_done), .result_h(result_h), .result_l(result_l)
    );

    // Multiplier model: done rises 'lat' started cycles after clear drops; lat=0 never finishes.
    int lat = 3;
    int mcnt = 0;
    always @(posedge clk) begin
        if (reset || mul_op_clear) begin
            mcnt        <= 0;
            mul_op_done <= 1'b0;
        end else if (mul_op_start && !mul_op_done) begin
            mcnt <= mcnt + 1;
            if (lat != 0 && mcnt + 1 == lat) begin
                mul_op_done          <= 1'b1;
                {result_h, result_l} <= {64'd0, multiplier} * {64'd0, multiplicand};
            end
        end
    end

    typedef struct {
        int           who;
        logic         err;
        logic [127:0] res;
    } exp_t;

    exp_t done_q[$];
    int   ack_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int   cyc = 0;
        int   done_cyc = -100;
        bit   open = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                open     = 1'b0;
                done_cyc = -100;
            end else begin
                if (req_ack != 2'b00) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", req_ack, 0);
                    end else begin
                        int w = ack_q.pop_front();
                        chk("ack_onehot", req_ack, w ? 2 : 1);
                        chk("ack_while_busy", open, 0);
                        chk("ack_spacing", (cyc - done_cyc >= 2), 1);
                        open = 1'b1;
                    end
                end
                if (req_done != 2'b00) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", req_done, 0);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_onehot", req_done, e.who ? 2 : 1);
                        chk("done_err", err, e.err);
                        chk("done_result", {out_result_h, out_result_l}, e.res);
                        chk("done_owner", owner, e.who);
                        open     = 1'b0;
                        done_cyc = cyc;
                    end
                end
                if (err && req_done == 2'b00)
                    chk("err_without_done", err, 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(int who, logic e, logic [127:0] r);
        exp_t x;
        x.who = who;
        x.err = e;
        x.res = r;
        ack_q.push_back(who);
        done_q.push_back(x);
    endtask

    task automatic req(int i, logic [63:0] a, logic [63:0] b);
        if (i == 0) begin
            req0_multiplier   = a;
            req0_multiplicand = b;
            req_valid[0]      = 1'b1;
        end else begin
            req1_multiplier   = a;
            req1_multiplicand = b;
            req_valid[1]      = 1'b1;
        end
    endtask

    task automatic wait_acks(logic [1:0] mask);
        logic [1:0] pend = mask;
        int n = 0;
        while (pend != 2'b00 && n < 200) begin
            tick();
            n++;
            if ((req_ack & pend) != 2'b00) begin
                req_valid = req_valid & ~(req_ack & pend);
                pend      = pend & ~req_ack;
            end
        end
        if (pend != 2'b00) chk("ack_timeout", pend, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((done_q.size() != 0 || ack_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (done_q.size() != 0 || ack_q.size() != 0)
            chk("drain_timeout", done_q.size() + ack_q.size(), 0);
        tick();
    endtask

    task automatic rst_checks();
        chk("rst_busy", busy, 0);
        chk("rst_clear", mul_op_clear, 1);
        chk("rst_start", mul_op_start, 0);
        chk("rst_pulses_owner", {req_ack, req_done, err, owner}, 0);
        chk("rst_operands", {multiplier, multiplicand}, 0);
        chk("rst_results", {out_result_h, out_result_l}, 0);
    endtask

    initial begin
        bit found;
        fork
            monitor();
        join_none

        tick();
        tick();
        reset = 1'b0;
        rst_checks();

        // Simultaneous requests straight out of reset: 0 first, then 1.
        lat = 3;
        expect_op(0, 1'b0, 128'd20);
        expect_op(1, 1'b0, 128'd42);
        req(0, 64'd5, 64'd4);
        req(1, 64'd6, 64'd7);
        wait_acks(2'b11);
        drain();

        // Second burst: last grant was 1, so 0 leads again.
        expect_op(0, 1'b0, 128'd81);
        expect_op(1, 1'b0, 128'd100);
        req(0, 64'd9, 64'd9);
        req(1, 64'd10, 64'd10);
        wait_acks(2'b11);
        drain();

        // Single request, 3-cycle multiplier.
        expect_op(0, 1'b0, 128'd20);
        req(0, 64'd5, 64'd4);
        wait_acks(2'b01);
        drain();

        // Late arrival of requester 1 during requester 0's RUN.
        lat = 5;
        expect_op(0, 1'b0, 128'd12);
        req(0, 64'd3, 64'd4);
        wait_acks(2'b01);
        repeat (3) tick();
        chk("late_in_run", {busy, mul_op_start}, 2'b11);
        expect_op(1, 1'b0, {64'd1, 64'd0});
        req(1, 64'h1_0000_0000, 64'h1_0000_0000);
        wait_acks(2'b10);
        drain();

        // Completion on the watchdog limit cycle: done wins.
        lat = 7;
        expect_op(1, 1'b0, {64'd1, 64'hFFFF_FFFF_FFFF_FFFE});
        req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_acks(2'b10);
        drain();

        // Watchdog expiry; a short req1 pulse while busy must be ignored.
        lat = 0;
        expect_op(0, 1'b1, 128'd0);
        req(0, 64'd3, 64'd3);
        wait_acks(2'b01);
        tick();
        chk("wd_run_entry", mul_op_start, 1);
        found = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 2) req_valid[1] = 1'b1;
            if (n == 4) req_valid[1] = 1'b0;
            tick();
            if (req_done != 2'b00) begin
                chk("wd_latency", n, 8);
                chk("wd_err", err, 1);
                chk("wd_rsp_clear", mul_op_clear, 1);
                chk("wd_ops_held", {multiplier, multiplicand}, {64'd3, 64'd3});
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("wd_timeout", 0, 1);
        drain();

        // Reset while requester 1 is in RUN: no done for the aborted operation.
        ack_q.push_back(1);
        req(1, 64'd11, 64'd11);
        wait_acks(2'b10);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rst_checks();
        repeat (20) tick();

        lat = 2;
        expect_op(0, 1'b0, 128'd42);
        req(0, 64'd7, 64'd6);
        wait_acks(2'b01);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WD_CYCLES, default 200: the watchdog limit, in cycles, on one multiplication in RUN.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester request; held high with operands stable until acked.
REQ-005 The block SHALL have ports req0_multiplier and req0_multiplicand, input, 64 bits each: the operands of requester 0.
REQ-006 The block SHALL have ports req1_multiplier and req1_multiplicand, input, 64 bits each: the operands of requester 1.
REQ-007 The block SHALL have port req_ack, output, 2 bits: a one-hot, 1-cycle pulse when that requester's operands are latched.
REQ-008 The block SHALL have port req_done, output, 2 bits: a one-hot, 1-cycle pulse when that requester's result is valid.
REQ-009 The block SHALL have port err, output, 1 bit: high together with req_done when the watchdog expired.
REQ-010 The block SHALL have ports out_result_h and out_result_l, output, 64 bits each: the registered result, held until the next RSP.
REQ-011 The block SHALL have port owner, output, 1 bit: the index of the current or last granted requester.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have ports mul_op_start and mul_op_clear, output, 1 bit each: the multiplier controls.
REQ-014 The block SHALL have ports multiplier and multiplicand, output, 64 bits each: the operands driven to the multiplier.
REQ-015 The block SHALL have port mul_op_done, input, 1 bit: the multiplier completion flag, level, held until clear.
REQ-016 The block SHALL have ports result_h and result_l, input, 64 bits each: the 128-bit product from the multiplier.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have states IDLE, CLR, RUN and RSP; the encoding is implementation choice.
REQ-019 In IDLE with req_valid != 0, the next edge SHALL select the winner, latch its operands into multiplier/multiplicand, set owner, pulse req_ack[winner] and enter CLR.
REQ-020 Arbitration SHALL be round-robin: if only one request is valid it wins; if both are valid, the requester not equal to last_grant wins.
REQ-021 last_grant SHALL update to owner on the transition RSP->IDLE.
REQ-022 CLR SHALL last exactly 1 cycle with mul_op_clear=1 and mul_op_start=0, then enter RUN.
REQ-023 In RUN, mul_op_start SHALL be 1 and held, mul_op_clear SHALL be 0, and the watchdog counter SHALL increment each cycle starting from 0.
REQ-024 In RUN with mul_op_done=1, the next edge SHALL latch result_h/result_l into out_result_h/out_result_l, pulse req_done[owner] with err=0, drop mul_op_start and enter RSP.
REQ-025 In RUN with the counter equal to WD_CYCLES-1 and mul_op_done=0, the next edge SHALL clear the out_result registers to 0, pulse req_done[owner] with err=1 and enter RSP.
REQ-026 If mul_op_done and the watchdog limit occur in the same cycle, done SHALL win and err SHALL be 0.
REQ-027 RSP SHALL last 1 cycle with mul_op_clear=1, then enter IDLE.
REQ-028 Requests SHALL be sampled only in IDLE; a req_valid asserted while busy=1 SHALL wait and receive no ack.
REQ-029 A req_valid dropped before its ack SHALL be ignored, with no side effects.
REQ-030 Operand outputs SHALL stay constant from CLR through RSP.
REQ-031 Minimum latency SHALL be: valid sampled at edge k -> ack at k+1 -> RUN at k+2 -> req_done one edge after mul_op_done is seen.
REQ-032 Back-to-back grants SHALL be spaced by at least 2 cycles after a req_done pulse.

Reset
REQ-033 When reset=1 at an edge, the block SHALL enter IDLE from any state and clear req_ack, req_done, err, busy, mul_op_start, owner, multiplier, multiplicand, out_result_h/l and the watchdog counter to 0, set mul_op_clear=1 and set last_grant=1.
REQ-034 After a reset mid-operation, no req_done SHALL be issued for the aborted operation.

Verification
REQ-035 Single request: req_valid=01, operands 5 and 4, model done after 3 cycles returning result_l=20 -> one ack[0], one done[0], out_result_l=20, err=0.
REQ-036 Simultaneous requests from reset: req_valid=11 -> requester 0 is served first, then requester 1; on a second simultaneous burst, 0 is served first again (last_grant=1).
REQ-037 Late arrival: req1 asserted during requester 0's RUN -> req1 is acked only after RSP, with no ack while busy.
REQ-038 Watchdog: WD_CYCLES=8, mul_op_done never asserted -> done[owner] and err=1 exactly 8 cycles after RUN entry, results 0, mul_op_clear=1 in RSP.
REQ-039 Reset in RUN: reset=1 for one cycle -> IDLE, all outputs at reset values, no req_done pulse; a new request is then served normally.
REQ-040 Done and watchdog limit in the same cycle -> err=0 and the product is latched.
